// File: rtl/fprint_pio_release.sv
// fprint_pio_release
//   Output-commit stage between the dual-core nios_fprint system and the
//   external LED PIO. Each core's LED write is held, tagged with its task ID,
//   until the fingerprint comparator confirms both cores agree for the stored
//   active task; only then is the value driven onto the board pins.
//
// Ports
//   osc_clk, reset_n               clock, asynchronous active-low reset
//   active_valid/active_task       strobe latching the currently executing task
//   cN_wr_valid/_task/_data        PIO write from core N (N = 0, 1) with task tag
//   fp_release/fp_mismatch/fp_task comparator verdict for fp_task
//   err_clear                      clears the sticky error flags
//   pio_out                        committed LED value
//   pending                        1 while at least one write is held
//   mismatch_err                   sticky: verdict mismatch, data disagreement, abort
//   overrun_err                    sticky: write from a core already holding an entry
//   timeout_err                    sticky: WAIT timeout
//
// Configuration
//   FPRINT_PIO_TIMEOUT_EN  when defined, a 16-bit timer aborts a WAIT that
//                          lasts TIMEOUT_CYC cycles; otherwise timeout_err is 0.

module fprint_pio_release #(
  parameter int WIDTH       = 4,
  parameter int TASK_W      = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              osc_clk,
  input  logic              reset_n,
  input  logic              active_valid,
  input  logic [TASK_W-1:0] active_task,
  input  logic              c0_wr_valid,
  input  logic [TASK_W-1:0] c0_wr_task,
  input  logic [WIDTH-1:0]  c0_wr_data,
  input  logic              c1_wr_valid,
  input  logic [TASK_W-1:0] c1_wr_task,
  input  logic [WIDTH-1:0]  c1_wr_data,
  input  logic              fp_release,
  input  logic              fp_mismatch,
  input  logic [TASK_W-1:0] fp_task,
  input  logic              err_clear,
  output logic [WIDTH-1:0]  pio_out,
  output logic              pending,
  output logic              mismatch_err,
  output logic              overrun_err,
  output logic              timeout_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e              state_q, state_d;
  logic [TASK_W-1:0]   task_q, task_d;
  logic                e0_valid_q, e0_valid_d, e1_valid_q, e1_valid_d;
  logic [WIDTH-1:0]    e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [WIDTH-1:0]    pio_q, pio_d;
  logic                pending_q, pending_d;
  logic                mismatch_q, mismatch_d;
  logic                overrun_q, overrun_d;

  logic in_wait, verdict_hit, abort, mism_hit, rel_hit, rel_ok, timeout_hit, flush;
  logic e0_keep, e1_keep, c0_hit, c1_hit;

`ifdef FPRINT_PIO_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
`else
  // The limit only matters when the timer is built in.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    task_d      = active_valid ? active_task : stored_task_hold();
    in_wait     = (state_q == ST_WAIT);
    verdict_hit = in_wait && (fp_task == task_q);
    // A task switch while holding writes means the held writes are stale.
    abort       = in_wait && active_valid && (active_task != task_q);
    // Mismatch wins over a simultaneous release.
    mism_hit    = verdict_hit && fp_mismatch;
    rel_hit     = verdict_hit && fp_release && !fp_mismatch && !abort &&
                  e0_valid_q && e1_valid_q;
    rel_ok      = rel_hit && (e0_data_q == e1_data_q);
    timeout_hit = 1'b0;
`ifdef FPRINT_PIO_TIMEOUT_EN
    timeout_hit = in_wait && (timer_q == 16'(TIMEOUT_CYC - 1)) &&
                  !(abort || mism_hit || rel_hit);
`endif
    flush       = abort || mism_hit || rel_hit || timeout_hit;

    // Entries are flushed first; same-cycle writes then see the new task and
    // land in empty slots, so they never count as overruns.
    e0_keep     = e0_valid_q && !flush;
    e1_keep     = e1_valid_q && !flush;
    c0_hit      = c0_wr_valid && (c0_wr_task == task_d);
    c1_hit      = c1_wr_valid && (c1_wr_task == task_d);

    e0_valid_d  = e0_keep || c0_hit;
    e1_valid_d  = e1_keep || c1_hit;
    e0_data_d   = (c0_hit && !e0_keep) ? c0_wr_data : e0_data_q;
    e1_data_d   = (c1_hit && !e1_keep) ? c1_wr_data : e1_data_q;

    pio_d       = rel_ok ? e0_data_q : pio_q;
    state_d     = (e0_valid_d || e1_valid_d) ? ST_WAIT : ST_IDLE;
    pending_d   = (state_d == ST_WAIT);

    // A set in the same cycle as err_clear wins.
    mismatch_d  = (mismatch_q && !err_clear) || abort || mism_hit || (rel_hit && !rel_ok);
    overrun_d   = (overrun_q && !err_clear) || (c0_hit && e0_keep) || (c1_hit && e1_keep);
`ifdef FPRINT_PIO_TIMEOUT_EN
    timeout_d   = (timeout_q && !err_clear) || timeout_hit;
    // Counts cycles of one continuous hold; any flush restarts it.
    timer_d     = (in_wait && !flush && state_d == ST_WAIT) ? timer_q + 16'd1 : 16'd0;
`endif
  end

  function automatic logic [TASK_W-1:0] stored_task_hold();
    return task_q;
  endfunction

  // NOTE: the held data words are reset along with their valid bits so the
  // block leaves reset fully deterministic; they are only a few flops.
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      task_q     <= '0;
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      e0_data_q  <= '0;
      e1_data_q  <= '0;
      pio_q      <= '0;
      pending_q  <= 1'b0;
      mismatch_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef FPRINT_PIO_TIMEOUT_EN
      timeout_q  <= 1'b0;
      timer_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q    <= state_d;
      task_q     <= task_d;
      e0_valid_q <= e0_valid_d;
      e1_valid_q <= e1_valid_d;
      e0_data_q  <= e0_data_d;
      e1_data_q  <= e1_data_d;
      pio_q      <= pio_d;
      pending_q  <= pending_d;
      mismatch_q <= mismatch_d;
      overrun_q  <= overrun_d;
`ifdef FPRINT_PIO_TIMEOUT_EN
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
`endif
    end
  end

  assign pio_out      = pio_q;
  assign pending      = pending_q;
  assign mismatch_err = mismatch_q;
  assign overrun_err  = overrun_q;
`ifdef FPRINT_PIO_TIMEOUT_EN
  assign timeout_err  = timeout_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fprint_pio_release.sv
// tb_fprint_pio_release
//   Directed self-checking bench for fprint_pio_release. Inputs change 1 time
//   unit after a rising edge; outputs are sampled at the same point, after the
//   edge they depend on. Build with FPRINT_PIO_TIMEOUT_EN to cover the timer.

module tb_fprint_pio_release;

  localparam int WIDTH  = 4;
  localparam int TASK_W = 4;

  logic              osc_clk = 1'b0;
  logic              reset_n;
  logic              active_valid;
  logic [TASK_W-1:0] active_task;
  logic              c0_wr_valid, c1_wr_valid;
  logic [TASK_W-1:0] c0_wr_task, c1_wr_task;
  logic [WIDTH-1:0]  c0_wr_data, c1_wr_data;
  logic              fp_release, fp_mismatch;
  logic [TASK_W-1:0] fp_task;
  logic              err_clear;
  logic [WIDTH-1:0]  pio_out;
  logic              pending, mismatch_err, overrun_err, timeout_err;

  int n_checks = 0;
  int n_fails  = 0;

  fprint_pio_release #(.WIDTH(WIDTH), .TASK_W(TASK_W), .TIMEOUT_CYC(16)) dut (
    .osc_clk      (osc_clk),
    .reset_n      (reset_n),
    .active_valid (active_valid),
    .active_task  (active_task),
    .c0_wr_valid  (c0_wr_valid),
    .c0_wr_task   (c0_wr_task),
    .c0_wr_data   (c0_wr_data),
    .c1_wr_valid  (c1_wr_valid),
    .c1_wr_task   (c1_wr_task),
    .c1_wr_data   (c1_wr_data),
    .fp_release   (fp_release),
    .fp_mismatch  (fp_mismatch),
    .fp_task      (fp_task),
    .err_clear    (err_clear),
    .pio_out      (pio_out),
    .pending      (pending),
    .mismatch_err (mismatch_err),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    active_valid = 1'b0;
    c0_wr_valid  = 1'b0;
    c1_wr_valid  = 1'b0;
    fp_release   = 1'b0;
    fp_mismatch  = 1'b0;
    err_clear    = 1'b0;
  endtask

  // Apply whatever strobes are set for one clock, then drop them.
  task automatic step();
    @(posedge osc_clk);
    #1;
    clear_strobes();
  endtask

  task automatic wr0(input logic [TASK_W-1:0] t, input logic [WIDTH-1:0] d);
    c0_wr_valid = 1'b1; c0_wr_task = t; c0_wr_data = d;
  endtask

  task automatic wr1(input logic [TASK_W-1:0] t, input logic [WIDTH-1:0] d);
    c1_wr_valid = 1'b1; c1_wr_task = t; c1_wr_data = d;
  endtask

  task automatic verdict(input logic rel, input logic mis, input logic [TASK_W-1:0] t);
    fp_release = rel; fp_mismatch = mis; fp_task = t;
  endtask

  task automatic set_task(input logic [TASK_W-1:0] t);
    active_valid = 1'b1; active_task = t;
  endtask

  task automatic clr_err();
    err_clear = 1'b1;
    step();
  endtask

  initial begin
    clear_strobes();
    active_task = '0; c0_wr_task = '0; c1_wr_task = '0;
    c0_wr_data = '0; c1_wr_data = '0; fp_task = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge osc_clk);
    #1;
    check("rst_pio", 32'(pio_out), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_errs", {29'h0, mismatch_err, overrun_err, timeout_err}, 32'h0);
    reset_n = 1'b1;
    step();

    // 1: matching writes then release -> committed one cycle later.
    set_task(4'd3); step();
    wr0(4'd3, 4'hA); wr1(4'd3, 4'hA); step();
    check("t1_pending_hi", 32'(pending), 32'h1);
    check("t1_pio_hold", 32'(pio_out), 32'h0);
    verdict(1'b1, 1'b0, 4'd3); step();
    check("t1_pio", 32'(pio_out), 32'hA);
    check("t1_pending_lo", 32'(pending), 32'h0);
    check("t1_no_err", 32'(mismatch_err), 32'h0);

    // 2: disagreeing data -> no commit, mismatch error.
    wr0(4'd3, 4'h5); step();
    wr1(4'd3, 4'h6); step();
    verdict(1'b1, 1'b0, 4'd3); step();
    check("t2_pio", 32'(pio_out), 32'hA);
    check("t2_mismatch", 32'(mismatch_err), 32'h1);
    check("t2_pending", 32'(pending), 32'h0);
    clr_err();
    check("t2_cleared", 32'(mismatch_err), 32'h0);

    // 3: double write from core0 -> overrun, first value kept.
    wr0(4'd3, 4'h3); step();
    wr0(4'd3, 4'hC); step();
    check("t3_overrun", 32'(overrun_err), 32'h1);
    wr1(4'd3, 4'h3); step();
    verdict(1'b1, 1'b0, 4'd3); step();
    check("t3_pio", 32'(pio_out), 32'h3);
    check("t3_no_mismatch", 32'(mismatch_err), 32'h0);
    clr_err();

    // Wrong tag ignored; lone-entry release and foreign-task verdicts ignored.
    wr1(4'd5, 4'h1); step();
    check("tag_ignored", 32'(pending), 32'h0);
    check("tag_no_overrun", 32'(overrun_err), 32'h0);
    wr0(4'd3, 4'h9); step();
    verdict(1'b1, 1'b0, 4'd3); step();
    check("half_rel_pending", 32'(pending), 32'h1);
    check("half_rel_pio", 32'(pio_out), 32'h3);
    verdict(1'b0, 1'b1, 4'd2); step();
    check("foreign_pending", 32'(pending), 32'h1);
    check("foreign_no_err", 32'(mismatch_err), 32'h0);
    wr1(4'd3, 4'h9); step();
    verdict(1'b1, 1'b0, 4'd3); step();
    check("late_rel_pio", 32'(pio_out), 32'h9);

    // 4: task switch while waiting -> abort; stale tag then ignored.
    wr0(4'd3, 4'h1); step();
    set_task(4'd7); step();
    check("t4_mismatch", 32'(mismatch_err), 32'h1);
    check("t4_pending", 32'(pending), 32'h0);
    wr0(4'd3, 4'h1); step();
    check("t4_stale_ignored", 32'(pending), 32'h0);
    set_task(4'd3); step();
    clr_err();

    // Write coinciding with release becomes a fresh entry, no overrun.
    wr0(4'd3, 4'h2); wr1(4'd3, 4'h2); step();
    verdict(1'b1, 1'b0, 4'd3); wr0(4'd3, 4'hF); step();
    check("same_cyc_pio", 32'(pio_out), 32'h2);
    check("same_cyc_pending", 32'(pending), 32'h1);
    check("same_cyc_no_overrun", 32'(overrun_err), 32'h0);
    wr1(4'd3, 4'hF); step();
    verdict(1'b1, 1'b0, 4'd3); step();
    check("same_cyc_commit", 32'(pio_out), 32'hF);

    // 5: mismatch and release together -> mismatch wins.
    wr0(4'd3, 4'h4); wr1(4'd3, 4'h4); step();
    verdict(1'b1, 1'b1, 4'd3); step();
    check("t5_mismatch", 32'(mismatch_err), 32'h1);
    check("t5_pio_held", 32'(pio_out), 32'hF);
    check("t5_pending", 32'(pending), 32'h0);
    clr_err();

    // 6: lone entry waits; times out only with the timer built in.
    wr0(4'd3, 4'h6); step();
    repeat (15) step();
    check("t6_no_timeout_yet", 32'(timeout_err), 32'h0);
    check("t6_still_pending", 32'(pending), 32'h1);
    step();
`ifdef FPRINT_PIO_TIMEOUT_EN
    check("t6_timeout", 32'(timeout_err), 32'h1);
    check("t6_idle", 32'(pending), 32'h0);
`else
    check("t6_no_timer", 32'(timeout_err), 32'h0);
    check("t6_waits", 32'(pending), 32'h1);
`endif
    check("t6_pio_held", 32'(pio_out), 32'hF);

    // Async reset mid-WAIT clears everything without a clock edge.
    wr0(4'd3, 4'h8); step();
    wr0(4'd3, 4'h8); step();
    check("pre_rst_overrun", 32'(overrun_err), 32'h1);
    check("pre_rst_pending", 32'(pending), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pio", 32'(pio_out), 32'h0);
    check("async_rst_pending", 32'(pending), 32'h0);
    check("async_rst_errs", {29'h0, mismatch_err, overrun_err, timeout_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
